// File: rtl/if_id_stage_pkg.sv
// Shared widths and constants for the IF/ID pipeline stage.
// Optional skid entry is enabled by defining IF_ID_STAGE_SKID_EN; SKID_EN mirrors it.
package if_id_stage_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned PC_WIDTH_DEF   = 32;

  // RISC-V addi x0,x0,0
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

`ifdef IF_ID_STAGE_SKID_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif

endpackage

// File: rtl/if_id_stage_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID stage, plus hold/flush controls.
// master drives fetch data, decode ready and controls; slave is the stage itself.
interface if_id_stage_if
  import if_id_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned PC_WIDTH   = PC_WIDTH_DEF
);

  logic                  in_valid;
  logic                  in_ready;
  logic [PC_WIDTH-1:0]   in_pc;
  logic [DATA_WIDTH-1:0] in_insn;
  logic                  out_valid;
  logic                  out_ready;
  logic [PC_WIDTH-1:0]   out_pc;
  logic [DATA_WIDTH-1:0] out_insn;
  logic                  hold;
  logic                  flush;

  modport master (
    output in_valid, in_pc, in_insn, out_ready, hold, flush,
    input  in_ready, out_valid, out_pc, out_insn
  );

  modport slave (
    input  in_valid, in_pc, in_insn, out_ready, hold, flush,
    output in_ready, out_valid, out_pc, out_insn
  );

endinterface

// File: rtl/if_id_stage_entry.sv
// One IF/ID storage entry: valid bit plus PC and instruction, with load and clear.
// load wins over clear; the parent never asserts load while flushing.
module if_id_stage_entry #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           PC_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_INSN = '0,
  parameter logic [PC_WIDTH-1:0]   RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  clear_i,
  input  logic [PC_WIDTH-1:0]   pc_i,
  input  logic [DATA_WIDTH-1:0] insn_i,
  output logic                  valid_o,
  output logic [PC_WIDTH-1:0]   pc_o,
  output logic [DATA_WIDTH-1:0] insn_o
);

  logic                  valid_q, valid_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0] insn_q, insn_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    insn_d  = insn_q;
    if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      insn_d  = insn_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      insn_q  <= RESET_INSN;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      insn_q  <= insn_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign insn_o  = insn_q;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: valid/ready on both sides with hold, flush and NOP on empty.
// Define IF_ID_STAGE_SKID_EN to add a skid entry so in_ready no longer depends on out_ready.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int unsigned         DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned         PC_WIDTH   = PC_WIDTH_DEF,
  parameter logic [31:0]         NOP_INSN   = RV_NOP,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input logic          clk,
  input logic          rst,
  if_id_stage_if.slave bus
);

  localparam logic [DATA_WIDTH-1:0] NOP_W = DATA_WIDTH'(NOP_INSN);

  logic                  ready_en_q;
  logic                  in_ready_c;
  logic                  out_valid_c;
  logic                  accept_c;
  logic                  emit_c;
  logic                  main_load_c;
  logic                  main_clear_c;
  logic [PC_WIDTH-1:0]   main_pc_d;
  logic [DATA_WIDTH-1:0] main_insn_d;
  logic                  main_valid;
  logic [PC_WIDTH-1:0]   main_pc;
  logic [DATA_WIDTH-1:0] main_insn;

  // Keeps in_ready low through reset and for the first edge after it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ready_en_q <= 1'b0;
    else     ready_en_q <= 1'b1;
  end

  assign out_valid_c  = main_valid & ~bus.hold;
  assign emit_c       = out_valid_c & bus.out_ready;
  assign accept_c     = bus.in_valid & in_ready_c;
  assign main_clear_c = bus.flush | emit_c;

`ifdef IF_ID_STAGE_SKID_EN
  logic                  skid_valid;
  logic [PC_WIDTH-1:0]   skid_pc;
  logic [DATA_WIDTH-1:0] skid_insn;
  logic                  from_skid_c;
  logic                  skid_load_c;
  logic                  skid_clear_c;

  assign in_ready_c   = ready_en_q & ~bus.hold & ~skid_valid;
  assign from_skid_c  = emit_c & skid_valid;
  assign main_load_c  = ~bus.flush & (from_skid_c | (accept_c & (~main_valid | emit_c)));
  assign main_pc_d    = from_skid_c ? skid_pc   : bus.in_pc;
  assign main_insn_d  = from_skid_c ? skid_insn : bus.in_insn;
  // Accept while main is stalled parks the instruction behind it
  assign skid_load_c  = ~bus.flush & accept_c & main_valid & ~emit_c;
  assign skid_clear_c = bus.flush | from_skid_c;

  if_id_stage_entry #(
    .DATA_WIDTH (DATA_WIDTH),
    .PC_WIDTH   (PC_WIDTH),
    .RESET_INSN (NOP_W),
    .RESET_PC   (RESET_PC)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load_c),
    .clear_i (skid_clear_c),
    .pc_i    (bus.in_pc),
    .insn_i  (bus.in_insn),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .insn_o  (skid_insn)
  );
`else
  assign in_ready_c  = ready_en_q & ~bus.hold & (~main_valid | bus.out_ready);
  assign main_load_c = ~bus.flush & accept_c;
  assign main_pc_d   = bus.in_pc;
  assign main_insn_d = bus.in_insn;
`endif

  if_id_stage_entry #(
    .DATA_WIDTH (DATA_WIDTH),
    .PC_WIDTH   (PC_WIDTH),
    .RESET_INSN (NOP_W),
    .RESET_PC   (RESET_PC)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (main_load_c),
    .clear_i (main_clear_c),
    .pc_i    (main_pc_d),
    .insn_i  (main_insn_d),
    .valid_o (main_valid),
    .pc_o    (main_pc),
    .insn_o  (main_insn)
  );

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_pc    = main_pc;
  assign bus.out_insn  = main_valid ? main_insn : NOP_W;

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Parametrised IF/ID pipeline stage register carrying PC and instruction from fetch to decode.
- Uses a valid/ready handshake on both sides. Supports flush, hold and bubble (NOP) injection.
- Optionally adds a skid entry so that in_ready is a pure register output, which breaks the combinational ready path back into fetch.
- Sits between the fetch unit and the decoder. It is the next generation of the plain instruction/PC latch.

Parameters:
- DATA_WIDTH, 32: instruction width in bits.
- PC_WIDTH, 32: program counter width in bits.
- NOP_INSN, 32'h0000_0013: instruction presented when the stage is empty or flushed (RISC-V addi x0,x0,0). Truncated or zero-extended to DATA_WIDTH.
- RESET_PC, 0: value of out_pc after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  PC_WIDTH  PC of the fetched instruction.
- in_insn  in  DATA_WIDTH  fetched instruction.
- out_valid  out  1  decode-side instruction valid.
- out_ready  in  1  decoder accepts this cycle.
- out_pc  out  PC_WIDTH  PC of the presented instruction.
- out_insn  out  DATA_WIDTH  presented instruction; NOP_INSN when the stage is empty.
- hold  in  1  freeze the stage: no accept, no emit.
- flush  in  1  discard all contents (branch or exception redirect).

Behaviour:
- Reset (asynchronous, active-high):
  - All valid bits go to 0; out_valid=0.
  - out_pc=RESET_PC, out_insn=NOP_INSN.
  - in_ready=1 one cycle after rst deasserts, and remains 0 while rst is high.
  - Reset asserted mid-transfer drops the in-flight data; nothing is emitted.
- Handshakes:
  - Accept occurs when in_valid & in_ready.
  - Emit occurs when out_valid & out_ready.
  - Data changes only on the clock edge after an accept.
  - Latency in->out is 1 cycle. Throughput is 1 instruction per cycle while out_ready=1.
- Main register holds {valid, pc, insn}:
  - Loads when empty, or when it emits in the same cycle as an accept.
  - When empty, out_pc holds its last value and out_insn=NOP_INSN.
- hold=1:
  - in_ready and out_valid are forced to 0 combinationally; internal state is preserved.
  - Releasing hold resumes with the identical contents.
- flush=1:
  - All valid bits are cleared at the next edge.
  - An accept in the same cycle is discarded (fetch sees in_ready but the data is dropped).
  - out_insn=NOP_INSN the cycle after.
- Priority: rst > flush > hold > normal.
  - flush+hold together means flush.
  - flush+emit together: the emit in the current cycle completes; contents are still cleared.
- Full condition: no accept while full. in_ready=0 until space frees.
- No data is ever lost or duplicated in the absence of flush or rst.

Optional Feature:
- Macro: IF_ID_STAGE_SKID_EN.
- Defined:
  - Adds a 2nd (skid) entry.
  - in_ready = ~skid_valid, a registered value with no out_ready dependency.
  - An accept while the main register is full and not emitting goes to skid.
  - On emit, skid moves to main.
  - Order is strictly FIFO; capacity is 2.
- Undefined:
  - Single entry; in_ready = ~main_valid | out_ready.
  - Throughput is unchanged; the combinational ready path is present.
- hold, flush and reset semantics are identical in both builds.

Decomposition:
- Shared package/include:
  - DATA_WIDTH and PC_WIDTH defaults.
  - NOP_INSN constant (named RV_NOP).
  - The IF_ID_STAGE_SKID_EN macro definition location.
- Sub-module: one entry register, stage_entry (valid+pc+insn with load/clear). Instantiated once, or twice under SKID_EN.

Test Plan:
- Reset: assert rst mid-stream with main full. Required: out_valid=0, out_pc=0, out_insn=32'h13 immediately; in_ready=1 the cycle after release.
- Streaming: in_valid=1, out_ready=1, PCs 0x00,0x04,0x08 with insns 0xA,0xB,0xC. Required: out shows each one cycle later, back-to-back, no gaps.
- Backpressure: out_ready=0 for 3 cycles while sending 0x10/0x14/0x18.
  - SKID_EN: two accepted, in_ready=0 on the third.
  - Non-skid: one accepted.
  - Both: release emits in order with no loss or duplication.
- Flush: flush=1 with a valid entry plus a simultaneous accept of PC 0x20. Required: next cycle out_valid=0, out_insn=0x13; PC 0x20 is never emitted.
- Hold: hold=1 for 4 cycles with PC 0x30 valid. Required: out_valid=0 and in_ready=0 throughout; after release, 0x30 is emitted exactly once.
- flush+hold in the same cycle with a full stage. Required: contents cleared; after hold release nothing is emitted and in_ready=1.
